// File: rtl/mem_stream_pkg.sv
`default_nettype none
// ============================================================================
// mem_stream_pkg : shared state type, widths and negation helper
// Revision       : 1.0
// ============================================================================
package mem_stream_pkg;

  localparam int MEM_W = 64;
  localparam int NEG_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } mse_state_t;

  // Each 32-bit half is negated independently, matching the datapath.
  function automatic logic [MEM_W-1:0] neg_halves(input logic [MEM_W-1:0] word);
    logic [NEG_W-1:0] w_hi;
    logic [NEG_W-1:0] w_lo;
    w_hi = -word[MEM_W-1:NEG_W];
    w_lo = -word[NEG_W-1:0];
    return {w_hi, w_lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mse_check_fifo.sv
`default_nettype none
// ============================================================================
// mse_check_fifo : small FIFO of issued words awaiting their results
// Revision       : 1.0
// ============================================================================
module mse_check_fifo
  import mem_stream_pkg::*;
#(
  parameter int WIDTH = MEM_W,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_COUNT);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stream_engine.sv
`default_nettype none
// ============================================================================
// mem_stream_engine : streams source words into the negation datapath at a
//                     paced rate and writes its results to a destination SRAM.
//                     Optional result checker: MEM_STREAM_ENGINE_CHECK_EN.
// Revision          : 1.0
// ============================================================================
module mem_stream_engine
  import mem_stream_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ISSUE_GAP = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [MEM_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [MEM_W-1:0]  wr_data,
  output logic              dp_input_valid,
  output logic [MEM_W-1:0]  dp_input_data,
  input  logic              dp_output_valid,
  input  logic [MEM_W-1:0]  dp_output_data,
  output logic [15:0]       err_count
);

  localparam int GAP_W = $clog2(ISSUE_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 3);

  mse_state_t        r_state;
  mse_state_t        w_next;
  logic [ADDR_W-1:0] r_src_base;
  logic [ADDR_W-1:0] r_dst_base;
  logic [ADDR_W-1:0] r_length;
  logic [ADDR_W-1:0] r_issue_idx;
  logic [ADDR_W-1:0] r_out_idx;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              w_accept;
  logic              w_last;
  logic              w_capture;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_last    = (r_issue_idx == r_length - ADDR_W'(1));
  // Results past the job length (or outside a job) are dropped.
  assign w_capture = (r_state != IDLE) && dp_output_valid && (r_out_idx != r_length);
  assign rd_addr   = r_src_base + r_issue_idx;

  always_comb begin
    w_next         = r_state;
    busy           = 1'b0;
    done           = 1'b0;
    rd_en          = 1'b0;
    dp_input_valid = 1'b0;
    dp_input_data  = '0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (length != '0) ? FETCH : DONE;
      end
      FETCH: begin
        busy   = 1'b1;
        rd_en  = 1'b1;
        w_next = ISSUE;
      end
      ISSUE: begin
        busy           = 1'b1;
        dp_input_valid = 1'b1;
        dp_input_data  = rd_data;
        w_next         = w_last ? DRAIN : GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (r_gap_cnt == '0) w_next = FETCH;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_out_idx == r_length) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_src_base  <= '0;
      r_dst_base  <= '0;
      r_length    <= '0;
      r_issue_idx <= '0;
      r_out_idx   <= '0;
      r_gap_cnt   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src_base  <= src_base;
        r_dst_base  <= dst_base;
        r_length    <= length;
        r_issue_idx <= '0;
        r_out_idx   <= '0;
      end
      // GAP holds ISSUE_GAP-2 cycles so the next ISSUE lands exactly ISSUE_GAP later.
      if (r_state == ISSUE) begin
        r_issue_idx <= r_issue_idx + ADDR_W'(1);
        r_gap_cnt   <= GAP_LOAD;
      end else if (r_state == GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
      wr_en <= w_capture;
      if (w_capture) begin
        wr_addr   <= r_dst_base + r_out_idx;
        wr_data   <= dp_output_data;
        r_out_idx <= r_out_idx + ADDR_W'(1);
      end
    end
  end

`ifdef MEM_STREAM_ENGINE_CHECK_EN
  logic [MEM_W-1:0] w_exp_word;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic             w_push;
  logic             w_pop;
  logic [15:0]      r_err_count;

  assign w_push = dp_input_valid && !w_fifo_full;
  assign w_pop  = w_capture && !w_fifo_empty;

  mse_check_fifo #(
    .WIDTH (MEM_W),
    .DEPTH (4)
  ) u_check_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (w_accept),
    .push      (w_push),
    .push_data (rd_data),
    .pop       (w_pop),
    .head      (w_exp_word),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  always_ff @(posedge clock) begin
    if (reset || w_accept) begin
      r_err_count <= '0;
    end else if (w_pop && (dp_output_data != neg_halves(w_exp_word))
                 && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_engine.sv
`default_nettype none
// ============================================================================
// tb_mem_stream_engine : scenario bench with SRAM and 2-cycle datapath models
// Revision             : 1.0
// ============================================================================
module tb_mem_stream_engine;

  localparam int ADDR_W    = 16;
  localparam int ISSUE_GAP = 3;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_base, dst_base, length;
  logic        busy, done, rd_en, wr_en, dp_input_valid, dp_output_valid;
  logic [15:0] rd_addr, wr_addr, err_count;
  logic [63:0] rd_data, wr_data, dp_input_data, dp_output_data;

  int checks;
  int errors;

  wr_t         exp_q[$];
  int          issue_rel[$];
  logic [63:0] iss_data[$];
  logic [15:0] rd_addrs[$];
  logic [15:0] wr_addrs[$];
  logic [63:0] wr_datas[$];
  int          wr_rel[$];
  int          done_rel, done_cnt, busy_bad;
  logic [15:0] err_rel1;

  logic [63:0] src_over [logic [15:0]];
  logic        v1;
  logic [63:0] d1;
  int          out_beats;
  int          corrupt_beat;

  always #5 clock = ~clock;

  mem_stream_engine #(.ADDR_W(ADDR_W), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dp_input_valid(dp_input_valid), .dp_input_data(dp_input_data),
    .dp_output_valid(dp_output_valid), .dp_output_data(dp_output_data),
    .err_count(err_count)
  );

  function automatic logic [63:0] src_word(input logic [15:0] a);
    if (src_over.exists(a)) return src_over[a];
    return {a ^ 16'hC3A5, 16'h0F1E, ~a, a + 16'h0101};
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] w);
    logic [31:0] hi, lo;
    hi = ~w[63:32] + 32'd1;
    lo = ~w[31:0] + 32'd1;
    return {hi, lo};
  endfunction

  // Source SRAM: one-cycle read latency.
  always @(posedge clock) rd_data <= rd_en ? src_word(rd_addr) : 64'h0;

  // Datapath: two-cycle negation pipeline, optionally corrupting one beat.
  always @(posedge clock) begin
    if (reset) begin
      v1 <= 1'b0; d1 <= '0; dp_output_valid <= 1'b0; dp_output_data <= '0; out_beats <= 0;
    end else begin
      v1 <= dp_input_valid;
      d1 <= neg64(dp_input_data);
      dp_output_valid <= v1;
      if (v1) begin
        dp_output_data <= (out_beats == corrupt_beat) ? (d1 ^ 64'h1) : d1;
        out_beats <= out_beats + 1;
      end
    end
  end

  task automatic push_exp(input logic [15:0] a, input logic [63:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Starts a job and records DUT activity per cycle relative to the start cycle.
  task automatic run_job(input logic [15:0] sb, input logic [15:0] db, input logic [15:0] len,
                         input int budget, input int poke_rel);
    bit exp_busy;
    issue_rel.delete(); iss_data.delete(); rd_addrs.delete();
    wr_addrs.delete(); wr_datas.delete(); wr_rel.delete();
    done_rel = -1; done_cnt = 0; busy_bad = 0; err_rel1 = 16'hFFFF;
    @(negedge clock);
    src_base = sb; dst_base = db; length = len; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    src_base = 16'hBEEF; dst_base = 16'hCAFE; length = 16'h0033;
    for (int rel = 1; rel <= budget; rel++) begin
      if (rel == 1) err_rel1 = err_count;
      if (rd_en) rd_addrs.push_back(rd_addr);
      if (dp_input_valid) begin
        issue_rel.push_back(rel);
        iss_data.push_back(dp_input_data);
      end
      if (wr_en) begin
        wr_addrs.push_back(wr_addr);
        wr_datas.push_back(wr_data);
        wr_rel.push_back(rel);
      end
      if (done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
      exp_busy = (done_rel < 0) && (len != 16'd0);
      if (busy !== exp_busy) busy_bad++;
      if (done_rel >= 0 && rel >= done_rel + 3) break;
      start = (rel + 1 == poke_rel);
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, rd_en, wr_en, dp_input_valid} !== 5'b0 || rd_addr !== 16'h0 ||
        wr_addr !== 16'h0 || wr_data !== 64'h0 || dp_input_data !== 64'h0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got ctl=%b rd_addr=%h wr_addr=%h wr_data=%h err=%h want all 0",
               {busy, done, rd_en, wr_en, dp_input_valid}, rd_addr, wr_addr, wr_data, err_count);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, done, rd_en, wr_en, dp_input_valid} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset got ctl=%b want 00000", {busy, done, rd_en, wr_en, dp_input_valid});
    end
  endtask

  task automatic test_single_word();
    wr_t e;
    src_over[16'h0010] = 64'h00000002_00000001;
    push_exp(16'h0020, 64'hFFFFFFFE_FFFFFFFF);
    run_job(16'h0010, 16'h0020, 16'd1, 40, 0);
    checks++;
    if (issue_rel.size() != 1 || issue_rel[0] != 2) begin
      errors++;
      $display("FAIL single_issue_cycle got n=%0d first=%0d want n=1 first=2", issue_rel.size(), issue_rel[0]);
    end
    checks++;
    if (wr_addrs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_wr_count got %0d want %0d", wr_addrs.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (wr_addrs.size() == 0 || wr_addrs[0] !== e.addr || wr_datas[0] !== e.data) begin
        errors++;
        $display("FAIL single_write got %h:%h want %h:%h", wr_addrs[0], wr_datas[0], e.addr, e.data);
      end
      if (wr_addrs.size() > 0) begin void'(wr_addrs.pop_front()); void'(wr_datas.pop_front()); end
    end
    checks++;
    if (done_rel < 0 || wr_rel.size() == 0 || done_rel != wr_rel[wr_rel.size()-1] + 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL single_done got rel=%0d cnt=%0d want one pulse right after last write", done_rel, done_cnt);
    end
    checks++;
    if (err_count !== 16'h0) begin
      errors++;
      $display("FAIL single_err_count got %0d want 0", err_count);
    end
  endtask

  task automatic test_burst();
    wr_t e;
    for (int i = 0; i < 8; i++) push_exp(16'h0200 + 16'(i), neg64(src_word(16'h0100 + 16'(i))));
    run_job(16'h0100, 16'h0200, 16'd8, 80, 4);
    checks++;
    if (issue_rel.size() != 8 || issue_rel[0] != 2) begin
      errors++;
      $display("FAIL burst_issue_count got n=%0d first=%0d want n=8 first=2", issue_rel.size(), issue_rel[0]);
    end
    for (int i = 1; i < issue_rel.size(); i++) begin
      checks++;
      if (issue_rel[i] - issue_rel[i-1] != ISSUE_GAP) begin
        errors++;
        $display("FAIL burst_gap[%0d] got %0d want %0d", i, issue_rel[i] - issue_rel[i-1], ISSUE_GAP);
      end
    end
    for (int i = 0; i < iss_data.size(); i++) begin
      checks++;
      if (iss_data[i] !== src_word(16'h0100 + 16'(i))) begin
        errors++;
        $display("FAIL burst_issue_data[%0d] got %h want %h", i, iss_data[i], src_word(16'h0100 + 16'(i)));
      end
    end
    checks++;
    if (wr_addrs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL burst_wr_count got %0d want %0d", wr_addrs.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (wr_addrs.size() == 0 || wr_addrs[0] !== e.addr || wr_datas[0] !== e.data) begin
        errors++;
        $display("FAIL burst_write got %h:%h want %h:%h", wr_addrs[0], wr_datas[0], e.addr, e.data);
      end
      if (wr_addrs.size() > 0) begin void'(wr_addrs.pop_front()); void'(wr_datas.pop_front()); end
    end
    checks++;
    if (busy_bad != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL burst_busy_done got busy_bad=%0d done_cnt=%0d want 0 and 1", busy_bad, done_cnt);
    end
  endtask

  task automatic test_empty_job();
    run_job(16'h0010, 16'h0020, 16'd0, 20, 0);
    checks++;
    if (done_rel != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL empty_done got rel=%0d cnt=%0d want rel=1 cnt=1", done_rel, done_cnt);
    end
    checks++;
    if (rd_addrs.size() != 0 || wr_addrs.size() != 0 || issue_rel.size() != 0 || busy_bad != 0) begin
      errors++;
      $display("FAIL empty_activity got rd=%0d wr=%0d iss=%0d busy_bad=%0d want all 0",
               rd_addrs.size(), wr_addrs.size(), issue_rel.size(), busy_bad);
    end
  endtask

  task automatic test_wrap();
    wr_t e;
    logic [15:0] exp_rd;
    for (int i = 0; i < 3; i++) push_exp(16'hFFFE + 16'(i), neg64(src_word(16'hFFFF + 16'(i))));
    run_job(16'hFFFF, 16'hFFFE, 16'd3, 50, 0);
    checks++;
    if (rd_addrs.size() != 3) begin
      errors++;
      $display("FAIL wrap_rd_count got %0d want 3", rd_addrs.size());
    end
    for (int i = 0; i < rd_addrs.size(); i++) begin
      exp_rd = 16'hFFFF + 16'(i);
      checks++;
      if (rd_addrs[i] !== exp_rd) begin
        errors++;
        $display("FAIL wrap_rd_addr[%0d] got %h want %h", i, rd_addrs[i], exp_rd);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (wr_addrs.size() == 0 || wr_addrs[0] !== e.addr || wr_datas[0] !== e.data) begin
        errors++;
        $display("FAIL wrap_write got %h:%h want %h:%h", wr_addrs[0], wr_datas[0], e.addr, e.data);
      end
      if (wr_addrs.size() > 0) begin void'(wr_addrs.pop_front()); void'(wr_datas.pop_front()); end
    end
    checks++;
    if (wr_addrs.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL wrap_tail got extra_wr=%0d done_cnt=%0d want 0 and 1", wr_addrs.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid_job();
    wr_t e;
    int  n_iss = 0;
    int  quiet_bad = 0;
    bit  hit = 0;
    @(negedge clock);
    src_base = 16'h0300; dst_base = 16'h0400; length = 16'd8; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      if (dp_input_valid) n_iss++;
      if (n_iss == 3) hit = 1;
      else @(negedge clock);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach_issue got %0d issues want 3", n_iss);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, rd_en, wr_en, dp_input_valid} !== 5'b0 || rd_addr !== 16'h0 ||
        wr_addr !== 16'h0 || wr_data !== 64'h0 || dp_input_data !== 64'h0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL abort_outputs got ctl=%b rd_addr=%h wr_addr=%h wr_data=%h in=%h want all 0",
               {busy, done, rd_en, wr_en, dp_input_valid}, rd_addr, wr_addr, wr_data, dp_input_data);
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (done || busy || wr_en || rd_en || dp_input_valid) quiet_bad++;
    end
    checks++;
    if (quiet_bad != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles want 0", quiet_bad);
    end
    for (int i = 0; i < 2; i++) push_exp(16'h0500 + 16'(i), neg64(src_word(16'h0330 + 16'(i))));
    run_job(16'h0330, 16'h0500, 16'd2, 40, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (wr_addrs.size() == 0 || wr_addrs[0] !== e.addr || wr_datas[0] !== e.data) begin
        errors++;
        $display("FAIL restart_write got %h:%h want %h:%h", wr_addrs[0], wr_datas[0], e.addr, e.data);
      end
      if (wr_addrs.size() > 0) begin void'(wr_addrs.pop_front()); void'(wr_datas.pop_front()); end
    end
    checks++;
    if (done_cnt != 1 || busy_bad != 0) begin
      errors++;
      $display("FAIL restart_done got cnt=%0d busy_bad=%0d want 1 and 0", done_cnt, busy_bad);
    end
  endtask

  task automatic test_checker();
    wr_t         e;
    logic [15:0] exp_err;
`ifdef MEM_STREAM_ENGINE_CHECK_EN
    exp_err = 16'd1;
`else
    exp_err = 16'd0;
`endif
    corrupt_beat = out_beats;
    push_exp(16'h0600, neg64(src_word(16'h0500)) ^ 64'h1);
    push_exp(16'h0601, neg64(src_word(16'h0501)));
    run_job(16'h0500, 16'h0600, 16'd2, 40, 0);
    corrupt_beat = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (wr_addrs.size() == 0 || wr_addrs[0] !== e.addr || wr_datas[0] !== e.data) begin
        errors++;
        $display("FAIL check_write got %h:%h want %h:%h", wr_addrs[0], wr_datas[0], e.addr, e.data);
      end
      if (wr_addrs.size() > 0) begin void'(wr_addrs.pop_front()); void'(wr_datas.pop_front()); end
    end
    checks++;
    if (err_count !== exp_err) begin
      errors++;
      $display("FAIL check_err_count got %0d want %0d", err_count, exp_err);
    end
    push_exp(16'h0710, neg64(src_word(16'h0700)));
    run_job(16'h0700, 16'h0710, 16'd1, 40, 0);
    exp_q.delete();
    checks++;
    if (err_rel1 !== 16'h0 || err_count !== 16'h0 || done_cnt != 1) begin
      errors++;
      $display("FAIL check_err_clear got rel1=%0d end=%0d done_cnt=%0d want 0 0 1", err_rel1, err_count, done_cnt);
    end
  endtask

  initial begin
    checks = 0; errors = 0; corrupt_beat = -1;
    reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; length = '0;
    test_reset();
    test_single_word();
    test_burst();
    test_empty_job();
    test_wrap();
    test_reset_mid_job();
    test_checker();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_stream_engine.md
# mem_stream_engine

Memory-side driver for the 64-bit negation datapath. Fetches `length` 64-bit words from a source SRAM and presents them to the datapath's `input_valid`/`input_data` port at the paced rate that port can absorb. It also captures every `output_valid`/`output_data` beat and writes it to a destination SRAM, then signals completion. It sits between the memory subsystem and the datapath, on the opposite end of the datapath's 64-bit stream interface.

## Interface
- `ADDR_W`, 16, word-address width of both memories and of `length`.
- `ISSUE_GAP`, 3, minimum cycles between consecutive `dp_input_valid` pulses (≥3).
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin a job; sampled only in IDLE.
- `src_base` in ADDR_W: first source word address, captured at start.
- `dst_base` in ADDR_W: first destination word address, captured at start.
- `length` in ADDR_W: word count, captured at start; 0 = empty job.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle completion pulse.
- `rd_en` out 1: source read strobe.
- `rd_addr` out ADDR_W: source read address.
- `rd_data` in 64: source read data, valid exactly 1 cycle after `rd_en`.
- `wr_en` out 1: destination write strobe.
- `wr_addr` out ADDR_W: destination write address.
- `wr_data` out 64: destination write data.
- `dp_input_valid` out 1: datapath input strobe, single-cycle pulses.
- `dp_input_data` out 64: datapath input word.
- `dp_output_valid` in 1: datapath result strobe.
- `dp_output_data` in 64: datapath result word.
- `err_count` out 16: checker mismatch count (see Configuration).

## Operation
- States:
  - IDLE: `start` & `length`≠0 → FETCH; `start` & `length`=0 → DONE.
  - FETCH: `rd_en`=1 → ISSUE.
  - ISSUE: `dp_input_valid`=1, `dp_input_data`=`rd_data`. Goes to DRAIN if this was the last word, else to GAP.
  - GAP: counts down; enters FETCH so that the next ISSUE falls exactly `ISSUE_GAP` cycles after the previous one.
  - DRAIN: waits until the output count reaches `length` → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Read addressing: `rd_addr` = `src_base` + issue index, modulo 2^ADDR_W (wrap allowed).
- Collection runs in every non-IDLE state, concurrent with issuing. On each `dp_output_valid`, the next cycle drives `wr_en`=1, `wr_data`=registered `dp_output_data`, `wr_addr`=`dst_base` + output index (mod 2^ADDR_W), then increments the output index.
- Results beyond `length`, or arriving in IDLE, are discarded. No write is issued for them.
- DRAIN exits only after the final write has been issued. `done` coincides with the cycle after the last `wr_en`.
- `start` while `busy` is ignored. The job parameters stay frozen for the whole job.
- No dependence on datapath latency; completion is purely output-count based.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wr_en` and `dp_input_valid` are 0. `rd_addr`, `wr_addr`, `wr_data`, `dp_input_data` and `err_count` are 0.
- Accepted `start` in cycle S:
  - `rd_en` in S+1.
  - First `dp_input_valid` in S+2.
  - Subsequent pulses at S+2+k·ISSUE_GAP.
- Empty job: `done` at S+1, no reads, no writes. `busy` stays 0 for that job.
- Write latency: exactly 1 cycle after each `dp_output_valid`.
- Reset mid-job aborts immediately: state IDLE, counters cleared, no `done` pulse. The datapath is reset by the same signal.
- `dp_input_valid` is never high on two cycles closer than `ISSUE_GAP` apart.

## Configuration
- `MEM_STREAM_ENGINE_CHECK_EN` defined:
  - The engine keeps a FIFO of issued words, depth 4.
  - Each captured result is compared against the two's-complement negation of each 32-bit half of the matching issued word.
  - Every mismatch saturating-increments `err_count`.
  - `err_count` clears on an accepted `start`.
- Undefined: no FIFO and no comparator; `err_count` is tied to 0.

## Structure
- Shared package `mem_stream_pkg`:
  - State enum `mse_state_t` (IDLE, FETCH, ISSUE, GAP, DRAIN, DONE).
  - Word-width constant `MEM_W`=64 and half-word constant `NEG_W`=32.
  - Function `neg_halves(word)` used by the checker.
- Sub-module `mse_check_fifo`: the depth-4 expected-value FIFO, instantiated only under the macro.

## Test plan
- Single word: src[0x10]=0x00000002_00000001, `length`=1, `dst_base`=0x20.
  - Expect `dp_input_valid` at S+2.
  - Expect one write to 0x20 of 0xFFFFFFFE_FFFFFFFF.
  - Expect `done` one cycle after that write; `err_count`=0.
- Burst pacing: `length`=8.
  - Input pulses exactly 3 cycles apart.
  - 8 writes to consecutive addresses.
  - `busy` high throughout; a single `done`.
- Empty job: `length`=0 → `done` at S+1; no `rd_en`, `wr_en` or `dp_input_valid`.
- Address wrap: `src_base`=0xFFFF and `dst_base`=0xFFFE with `length`=3.
  - Reads go to 0xFFFF, 0x0000, 0x0001.
  - Writes go to 0xFFFE, 0xFFFF, 0x0000.
- Reset mid-job: assert `reset` after the 3rd issue of 8.
  - All outputs 0 the next cycle; no `done`.
  - A fresh `start` with `length`=2 then completes normally.
- Checker (macro on): the bench corrupts one result word.
  - Expect `err_count`=1.
  - A new `start` clears it to 0.
